pc_fetch_ctrl: RTL and testbench

Parametrised next-generation PC generator and fetch requester for the CPU front end. It extends the basic free-running PC with stall handling, a single-entry branch-redirect buffer, exception flush, and a memory acknowledge handshake.
It drives the instruction-memory address and chip enable, and feeds the IF/ID stage.
It sits between the ctrl unit (stall/flush), the EX/ID branch logic, and instruction ROM/cache.

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/pc_redirect_buf.sv | 38 +++
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the front-end PC generator.
package pc_fetch_ctrl_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int          DEF_ADDR_W       = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEF_INC          = 4;

  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_REQ  = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a branch target that arrived while the PC could not move.
module pc_redirect_buf
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_consume,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_pend_valid,
  output logic [ADDR_W-1:0] o_pend_addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  // Load beats consume so a branch arriving while the old target is used gets kept.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pend_valid = r_valid;
  assign o_pend_addr  = r_addr;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC generator and instruction fetch requester with stall, branch redirect buffer and flush.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter int unsigned        INC          = DEF_INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              ce
);

  pc_state_e         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ce;

  logic              w_active;
  logic              w_flush;
  logic              w_advance;
  logic              w_load;
  logic              w_consume;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_addr;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_active  = (r_state != PC_IDLE);
  assign w_flush   = flush && w_active;
  assign w_advance = ((r_state == PC_REQ) && imem_ack && !stall) ||
                     ((r_state == PC_HOLD) && !stall);

  // A branch is buffered unless it can be taken directly by this cycle's advance.
  assign w_load    = w_active && !flush && branch_flag_i && (!w_advance || w_pend_valid);
  assign w_consume = w_advance && !flush;

  assign w_next_pc = w_pend_valid  ? w_pend_addr :
                     branch_flag_i ? branch_target_address_i :
                                     r_pc + ADDR_W'(INC);

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_clear      (w_flush),
    .i_consume    (w_consume),
    .i_addr       (branch_target_address_i),
    .o_pend_valid (w_pend_valid),
    .o_pend_addr  (w_pend_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= PC_IDLE;
      r_pc    <= RESET_VECTOR;
      r_ce    <= ChipDisable;
    end else begin
      case (r_state)
        PC_IDLE: begin
          r_state <= PC_REQ;
          r_ce    <= ChipEnable;
        end
        PC_REQ, PC_HOLD: begin
          if (flush) begin
            r_pc    <= new_pc;
            r_state <= PC_REQ;
            r_ce    <= ChipEnable;
          end else if (w_advance) begin
            r_pc    <= w_next_pc;
            r_state <= PC_REQ;
            r_ce    <= ChipEnable;
          end else if ((r_state == PC_REQ) && imem_ack) begin
            r_state <= PC_HOLD;
            r_ce    <= ChipDisable;
          end
        end
        default: begin
          r_state <= PC_IDLE;
          r_ce    <= ChipDisable;
        end
      endcase
    end
  end

  assign pc = r_pc;
  assign ce = r_ce;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_ack;
  logic [31:0] pc;
  logic        ce;

  pc_fetch_ctrl #(
    .ADDR_W       (32),
    .RESET_VECTOR (RV),
    .INC          (4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem_ack                (imem_ack),
    .pc                      (pc),
    .ce                      (ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t q_exp[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cycle       = 0;

  // Reference model: "fetching" flag, current pc, and a list of pending redirect targets.
  bit          mStarted;
  logic        mFetching;
  logic [31:0] mPc;
  logic [31:0] mPending[$];

  task automatic modelReset();
    mStarted  = 1'b0;
    mFetching = 1'b0;
    mPc       = RV;
    mPending.delete();
  endtask

  task automatic modelStep(input logic s, input logic f, input logic [31:0] np,
                           input logic b, input logic [31:0] bt, input logic a);
    bit          moves;
    logic [31:0] target;
    if (!mStarted) begin
      mStarted  = 1'b1;
      mFetching = 1'b1;
    end else if (f) begin
      mPc       = np;
      mFetching = 1'b1;
      mPending.delete();
    end else begin
      moves = mFetching ? (a && !s) : !s;
      if (moves) begin
        if (mPending.size() > 0) begin
          target = mPending.pop_front();
          if (b) mPending.push_back(bt);
        end else if (b) begin
          target = bt;
        end else begin
          target = mPc + 32'd4;
        end
        mPc       = target;
        mFetching = 1'b1;
      end else begin
        if (mFetching && a) mFetching = 1'b0;
        if (b) begin
          mPending.delete();
          mPending.push_back(bt);
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic gotCe, input logic [31:0] gotPc,
                             input logic wantCe, input logic [31:0] wantPc);
    nCompared++;
    if (gotCe !== wantCe || gotPc !== wantPc) begin
      nMismatched++;
      $display("[TB] FAIL %s: got ce=%0b pc=%h, expected ce=%0b pc=%h",
               name, gotCe, gotPc, wantCe, wantPc);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.ce  = mFetching;
    e.pc  = mPc;
    e.cyc = cycle;
    q_exp.push_back(e);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, and queues the result.
  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] np,
                               input logic b, input logic [31:0] bt, input logic a);
    stall                   = s;
    flush                   = f;
    new_pc                  = np;
    branch_flag_i           = b;
    branch_target_address_i = bt;
    imem_ack                = a;
    modelStep(s, f, np, b, bt, a);
    @(posedge clk);
    #1;
    cycle++;
    pushExpected();
  endtask

  task automatic pulseReset();
    #1;
    rst = 1'b0;
    q_exp.delete();
    #1;
    checkOutput("async_reset", ce, pc, 1'b0, RV);
    modelReset();
    pushExpected();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the oldest queued expectation each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        checkOutput($sformatf("cycle%0d", e.cyc), ce, pc, e.ce, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0; imem_ack = 1'b0;
    #1;
    rst = 1'b0;
    modelReset();
    pushExpected();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] sequential fetch after reset");
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] ack withheld");
    applyStimulus(0, 1, 32'h10, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] stall with branch into HOLD");
    applyStimulus(0, 1, 32'h1C, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 32'h100, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] newest branch wins");
    applyStimulus(0, 0, 0, 1, 32'h100, 0);
    applyStimulus(0, 0, 0, 1, 32'h200, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] flush during HOLD with pending target");
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 32'h300, 1);
    applyStimulus(1, 1, 32'h180, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] address wrap and async reset");
    applyStimulus(0, 1, 32'hFFFF_FFF8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    pulseReset();
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      logic        s, f, b, a;
      logic [31:0] np, bt;
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 19) == 0);
      b  = ($urandom_range(0, 5) == 0);
      a  = ($urandom_range(0, 3) != 0);
      np = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      bt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 199) == 0) pulseReset();
      else applyStimulus(s, f, np, b, bt, a);
    end

    repeat (3) @(posedge clk);
    #1;
    if (q_exp.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
